// File: rtl/wolfram_ca_pkg.sv
// Shared types and constants for the elementary cellular-automaton engine.
package wolfram_ca_pkg;

    localparam int RULE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Boundary handling for the neighbours beyond the two edge cells; 2'b11 behaves as zero.
    typedef enum logic [1:0] {
        B_ZERO = 2'b00,
        B_ONE  = 2'b01,
        B_WRAP = 2'b10
    } bound_t;

endpackage

// File: rtl/ca_rule_lut.sv
// Single-cell Wolfram rule lookup: the {left, centre, right} neighbourhood selects one rule bit.
module ca_rule_lut
    import wolfram_ca_pkg::*;
(
    input  logic [RULE_W-1:0] i_rule,
    input  logic              i_l,
    input  logic              i_c,
    input  logic              i_r,
    output logic              o_y
);

    assign o_y = i_rule[{i_l, i_c, i_r}];

endmodule

// File: rtl/wolfram_ca_engine.sv
// 1-D elementary cellular-automaton engine: loads a seed, then iterates a run-time rule
// for a programmed number of generations with selectable edge behaviour.
module wolfram_ca_engine
    import wolfram_ca_pkg::*;
#(
    parameter int                N_CELLS      = 16,
    parameter int                GEN_W        = 8,
    parameter logic [RULE_W-1:0] DEFAULT_RULE = 8'h18
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [RULE_W-1:0]  cfg_rule,
    input  logic [N_CELLS-1:0] cfg_seed,
    input  logic [GEN_W-1:0]   cfg_gens,
    input  logic [1:0]         cfg_bound,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic [N_CELLS-1:0] cells,
    output logic [GEN_W-1:0]   gen_count
);

    state_t               r_state;
    state_t               w_stateNext;
    logic [RULE_W-1:0]    r_rule;
    logic [1:0]           r_bound;
    logic [GEN_W-1:0]     r_gens;
    logic [N_CELLS-1:0]   r_cells;
    logic [GEN_W-1:0]     r_genCount;

    logic                 w_accept;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_edgeLeft;
    logic                 w_edgeRight;
    logic [N_CELLS+1:0]   w_ext;
    logic [N_CELLS-1:0]   w_next;
    logic [GEN_W-1:0]     w_genInc;

    // Ready is forced low while reset is held so no job can be offered during reset.
    assign cfg_ready = (r_state == S_IDLE) && rst_n;
    assign w_accept  = cfg_valid && cfg_ready;
    assign w_genInc  = r_genCount + GEN_W'(1);

    // Choose the virtual neighbours beyond the leftmost (c[N]) and rightmost (c[-1]) cells.
    always_comb begin
        w_edgeLeft  = 1'b0;
        w_edgeRight = 1'b0;
        case (r_bound)
            B_ONE: begin
                w_edgeLeft  = 1'b1;
                w_edgeRight = 1'b1;
            end
            B_WRAP: begin
                w_edgeLeft  = r_cells[0];
                w_edgeRight = r_cells[N_CELLS-1];
            end
            default: begin
                w_edgeLeft  = 1'b0;
                w_edgeRight = 1'b0;
            end
        endcase
    end

    assign w_ext = {w_edgeLeft, r_cells, w_edgeRight};

    // One lookup per cell; every cell sees only the old generation, so all update together.
    for (genvar gi = 0; gi < N_CELLS; gi++) begin : g_cell
        ca_rule_lut u_lut (
            .i_rule (r_rule),
            .i_l    (w_ext[gi+2]),
            .i_c    (w_ext[gi+1]),
            .i_r    (w_ext[gi]),
            .o_y    (w_next[gi])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and status decode; abort leaves RUN without a done pulse.
    always_comb begin
        w_stateNext = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_stateNext = (cfg_gens == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (abort) begin
                    w_stateNext = S_IDLE;
                end else if (w_genInc == r_gens) begin
                    w_stateNext = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_stateNext = S_IDLE;
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Job latch on handshake, then one generation per RUN cycle unless aborted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rule     <= DEFAULT_RULE;
            r_bound    <= B_ZERO;
            r_gens     <= '0;
            r_cells    <= '0;
            r_genCount <= '0;
        end else begin
            if (w_accept) begin
                r_rule     <= cfg_rule;
                r_bound    <= cfg_bound;
                r_gens     <= cfg_gens;
                r_cells    <= cfg_seed;
                r_genCount <= '0;
            end else if ((r_state == S_RUN) && !abort) begin
                r_cells    <= w_next;
                r_genCount <= w_genInc;
            end
        end
    end

    assign busy      = w_busy;
    assign done      = w_done;
    assign cells     = r_cells;
    assign gen_count = r_genCount;

endmodule

// File: tb/tb_wolfram_ca_engine.sv
// Self-checking bench for wolfram_ca_engine with an 8-cell instance.
module tb_wolfram_ca_engine;

    localparam int NC = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [7:0]    cfg_rule = 8'h00;
    logic [NC-1:0] cfg_seed = '0;
    logic [7:0]    cfg_gens = 8'h00;
    logic [1:0]    cfg_bound = 2'b00;
    logic          abort = 1'b0;
    logic          busy;
    logic          done;
    logic [NC-1:0] cells;
    logic [7:0]    gen_count;

    int checks = 0;
    int failures = 0;
    bit cmpEn = 1'b0;

    // Reference model state (protocol phase kept as plain flags and a countdown)
    logic [7:0] mCells = '0;
    logic [7:0] mGen = '0;
    logic [7:0] mRule = 8'h18;
    logic [1:0] mBound = 2'b00;
    int         mLeft = 0;
    bit         mActive = 1'b0;
    bit         mDone = 1'b0;

    wolfram_ca_engine #(.N_CELLS(NC), .GEN_W(8), .DEFAULT_RULE(8'h18)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_rule  (cfg_rule),
        .cfg_seed  (cfg_seed),
        .cfg_gens  (cfg_gens),
        .cfg_bound (cfg_bound),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .cells     (cells),
        .gen_count (gen_count)
    );

    always #5 clk = ~clk;

    // One generation computed directly from the rule number and neighbourhood value.
    function automatic logic [7:0] caStep(input logic [7:0] c, input logic [7:0] rule,
                                          input logic [1:0] bnd);
        logic [7:0] n;
        int l, m, r, idx;
        n = '0;
        for (int i = 0; i < NC; i++) begin
            m = int'(c[i]);
            if (i == NC - 1) l = (bnd == 2'b01) ? 1 : (bnd == 2'b10) ? int'(c[0]) : 0;
            else             l = int'(c[i+1]);
            if (i == 0)      r = (bnd == 2'b01) ? 1 : (bnd == 2'b10) ? int'(c[NC-1]) : 0;
            else             r = int'(c[i-1]);
            idx  = l * 4 + m * 2 + r;
            n[i] = ((int'(rule) >> idx) & 1) == 1;
        end
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Behavioural model advancing on the same clock as the DUT
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mCells <= '0; mGen <= '0; mRule <= 8'h18; mBound <= 2'b00;
            mLeft <= 0; mActive <= 1'b0; mDone <= 1'b0;
        end else if (mDone) begin
            mDone <= 1'b0;
        end else if (mActive) begin
            if (abort) begin
                mActive <= 1'b0;
            end else begin
                mCells <= caStep(mCells, mRule, mBound);
                mGen   <= mGen + 8'd1;
                mLeft  <= mLeft - 1;
                if (mLeft == 1) begin
                    mActive <= 1'b0;
                    mDone   <= 1'b1;
                end
            end
        end else if (cfg_valid) begin
            mRule  <= cfg_rule;
            mBound <= cfg_bound;
            mCells <= cfg_seed;
            mGen   <= '0;
            if (cfg_gens == 8'd0) mDone <= 1'b1;
            else begin
                mActive <= 1'b1;
                mLeft   <= int'(cfg_gens);
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmpEn) begin
            checkOutput("cells", 32'(cells), 32'(mCells));
            checkOutput("gen_count", 32'(gen_count), 32'(mGen));
            checkOutput("busy", 32'(busy), 32'(mActive));
            checkOutput("done", 32'(done), 32'(mDone));
            checkOutput("cfg_ready", 32'(cfg_ready), 32'(rst_n && !mActive && !mDone));
        end
    end

    // Offer one job, optionally abort in RUN cycle abortAt, and report the cycle done was seen.
    task automatic applyStimulus(input logic [7:0] rule, input logic [7:0] seed,
                                 input logic [7:0] gens, input logic [1:0] bnd,
                                 input int abortAt, output int doneCycle, output bit sawBusy);
        bit finished;
        cfg_rule = rule; cfg_seed = seed; cfg_gens = gens; cfg_bound = bnd;
        cfg_valid = 1'b1;
        @(posedge clk); #2;
        cfg_valid = 1'b0;
        doneCycle = -1;
        sawBusy   = 1'b0;
        finished  = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            abort = (k == abortAt);
            if (busy) sawBusy = 1'b1;
            if (done) doneCycle = k;
            @(posedge clk); #2;
            abort = 1'b0;
            cfg_rule = 8'($urandom); cfg_seed = 8'($urandom);
            cfg_gens = 8'($urandom); cfg_bound = 2'($urandom);
            if (doneCycle >= 0 || k == abortAt) begin
                finished = 1'b1;
                break;
            end
        end
        checkOutput("jobFinished", 32'(finished), 32'd1);
    endtask

    initial begin
        int  dc;
        bit  sb;
        int  expDc;
        int  ab;
        logic [7:0] g;

        @(posedge clk);
        cmpEn = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("resetCells", 32'(cells), 32'h0);
        checkOutput("resetReady", 32'(cfg_ready), 32'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("readyAfterReset", 32'(cfg_ready), 32'h1);
        @(posedge clk); #2;

        applyStimulus(8'h5A, 8'h10, 8'd1, 2'b00, 0, dc, sb);
        checkOutput("rule5A cells", 32'(cells), 32'h28);
        checkOutput("rule5A gen", 32'(gen_count), 32'd1);
        checkOutput("rule5A doneCycle", 32'(dc), 32'd2);

        applyStimulus(8'h18, 8'h01, 8'd1, 2'b10, 0, dc, sb);
        checkOutput("rule18 wrap cells", 32'(cells), 32'h80);
        applyStimulus(8'h18, 8'h01, 8'd1, 2'b00, 0, dc, sb);
        checkOutput("rule18 zero cells", 32'(cells), 32'h00);

        applyStimulus(8'h5A, 8'hA5, 8'd0, 2'b00, 0, dc, sb);
        checkOutput("gens0 cells", 32'(cells), 32'hA5);
        checkOutput("gens0 doneCycle", 32'(dc), 32'd1);
        checkOutput("gens0 busy", 32'(sb), 32'd0);
        checkOutput("gens0 gen", 32'(gen_count), 32'd0);

        applyStimulus(8'h5A, 8'h10, 8'd4, 2'b00, 3, dc, sb);
        checkOutput("abort doneCycle", 32'(dc), 32'hFFFFFFFF);
        checkOutput("abort gen", 32'(gen_count), 32'd2);
        checkOutput("abort cells", 32'(cells), 32'h44);
        checkOutput("abort idle", 32'(cfg_ready), 32'd1);

        // Reset in the middle of a run, then a fresh job under the reset rule value
        cfg_rule = 8'h5A; cfg_seed = 8'h10; cfg_gens = 8'd10; cfg_bound = 2'b00;
        cfg_valid = 1'b1;
        @(posedge clk); #2;
        cfg_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midReset cells", 32'(cells), 32'h0);
        checkOutput("midReset gen", 32'(gen_count), 32'h0);
        checkOutput("midReset done", 32'(done), 32'h0);
        checkOutput("midReset busy", 32'(busy), 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #2;
        applyStimulus(8'h18, 8'h01, 8'd1, 2'b10, 0, dc, sb);
        checkOutput("postReset cells", 32'(cells), 32'h80);

        // cfg_valid held high through DONE: next job only on the following IDLE cycle
        cfg_rule = 8'h5A; cfg_seed = 8'h10; cfg_gens = 8'd2; cfg_bound = 2'b00;
        cfg_valid = 1'b1;
        repeat (3) begin @(posedge clk); #2; end
        checkOutput("held done", 32'(done), 32'd1);
        checkOutput("held readyInDone", 32'(cfg_ready), 32'd0);
        @(posedge clk); #2;
        checkOutput("held idleReady", 32'(cfg_ready), 32'd1);
        checkOutput("held idleBusy", 32'(busy), 32'd0);
        @(posedge clk); #2;
        cfg_valid = 1'b0;
        checkOutput("held secondJob", 32'(busy), 32'd1);
        checkOutput("held secondJob cells", 32'(cells), 32'h10);
        repeat (3) begin @(posedge clk); #2; end

        // Longest job: gen_count must reach 255 without wrapping
        applyStimulus(8'h96, 8'h01, 8'd255, 2'b10, 0, dc, sb);
        checkOutput("long gen", 32'(gen_count), 32'd255);
        checkOutput("long doneCycle", 32'(dc), 32'd256);

        // Randomized jobs with random aborts and idle gaps
        for (int j = 0; j < 60; j++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #2;
                cfg_rule = 8'($urandom); cfg_seed = 8'($urandom);
            end
            g  = 8'($urandom_range(0, 12));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, int'(g) + 1)) : 0;
            applyStimulus(8'($urandom), 8'($urandom), g, 2'($urandom), ab, dc, sb);
            expDc = (ab == 0 || ab > int'(g)) ? int'(g) + 1 : -1;
            checkOutput("rand doneCycle", 32'(dc), 32'(expDc));
        end

        @(posedge clk); #2;
        cmpEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
